// File: rtl/sim_status_monitor.sv
// End-of-test monitor: retire watchdog, writeback pass/fail magic detection,
// console byte snoop on the AXI write channel, and a retired-instruction counter.
module sim_status_monitor #(
  parameter int                 RETIRE_CH  = 2,
  parameter int                 WB_LANES   = 2,
  parameter int                 WB_W       = 64,
  parameter int                 ADDR_W     = 40,
  parameter int                 DATA_W     = 128,
  parameter int                 WDOG_W     = 32,
  parameter logic [ADDR_W-1:0]  CON_ADDR   = 40'h90000000,
  parameter logic [WB_W-1:0]    PASS_VAL   = 64'h444333222,
  parameter logic [WB_W-1:0]    FAIL_VAL   = 64'h2382348720,
  parameter int                 FIFO_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic [WDOG_W-1:0]          cfg_wdog_window,
  input  logic [RETIRE_CH-1:0]       retire_vld,
  input  logic [WB_LANES-1:0]        wb_vld,
  input  logic [WB_LANES*WB_W-1:0]   wb_data,
  input  logic                       awvalid,
  input  logic                       awready,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic [3:0]                 awlen,
  input  logic                       wvalid,
  input  logic                       wready,
  input  logic                       wlast,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       con_rd,
  output logic                       con_vld,
  output logic [7:0]                 con_byte,
  output logic                       con_ovf,
  output logic                       status_done,
  output logic                       status_pass,
  output logic                       status_fail,
  output logic                       status_timeout,
  output logic [31:0]                inst_cnt
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int N_WORDS = DATA_W / 32;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int PC_W    = $clog2(RETIRE_CH + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WDOG_W-1:0] win_cnt_q, win_cnt_d;
  logic              seen_q, seen_d;
  logic [31:0]       inst_cnt_q, inst_cnt_d;
  logic              hit_q, hit_d;
  logic              ovf_q, ovf_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic              any_retire;
  logic [PC_W-1:0]   retire_pop;
  logic [32:0]       inst_sum;
  logic              hit_fail, hit_pass, wdog_expire;

  logic              aw_hs, w_last_hs, aw_match, hit_eff;
  logic              push, push_ok, pop, full;
  logic [7:0]        push_byte;

  // Retire accounting and magic-value detection
  always_comb begin
    retire_pop = '0;
    for (int i = 0; i < RETIRE_CH; i++) begin
      retire_pop = retire_pop + PC_W'(retire_vld[i]);
    end
    any_retire = |retire_vld;
    inst_sum   = {1'b0, inst_cnt_q} + 33'(retire_pop);

    hit_fail = 1'b0;
    hit_pass = 1'b0;
    for (int l = 0; l < WB_LANES; l++) begin
      if (wb_vld[l] && (wb_data[l*WB_W +: WB_W] == FAIL_VAL)) hit_fail = 1'b1;
      if (wb_vld[l] && (wb_data[l*WB_W +: WB_W] == PASS_VAL)) hit_pass = 1'b1;
    end
  end

  // FSM next state, watchdog window and counter; all frozen once terminal
  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    seen_d      = seen_q;
    inst_cnt_d  = inst_cnt_q;
    wdog_expire = 1'b0;

    if (state_q == ST_RUN) begin
      if (cfg_wdog_window == '0) begin
        win_cnt_d = '0;
        seen_d    = 1'b0;
      end else if (win_cnt_q >= (cfg_wdog_window - WDOG_W'(1))) begin
        wdog_expire = ~(seen_q | any_retire);
        win_cnt_d   = '0;
        seen_d      = 1'b0;
      end else begin
        win_cnt_d = win_cnt_q + WDOG_W'(1);
        seen_d    = seen_q | any_retire;
      end

      inst_cnt_d = inst_sum[32] ? 32'hFFFF_FFFF : inst_sum[31:0];

      if (hit_fail)         state_d = ST_FAIL;
      else if (hit_pass)    state_d = ST_PASS;
      else if (wdog_expire) state_d = ST_TIMEOUT;
    end
  end

  // Console snoop: one outstanding AW; a same-cycle AW supplies the W beat's address
  always_comb begin
    aw_hs     = awvalid & awready;
    w_last_hs = wvalid & wready & wlast;
    aw_match  = (awaddr == CON_ADDR) && (awlen == 4'd0);
    hit_eff   = aw_hs ? aw_match : hit_q;
    hit_d     = w_last_hs ? 1'b0 : hit_eff;

    push      = 1'b0;
    push_byte = 8'h00;
    if (w_last_hs && hit_eff) begin
      for (int k = 0; k < N_WORDS; k++) begin
        if (wstrb == (STRB_W'(4'hF) << (4 * k))) begin
          push      = 1'b1;
          push_byte = wdata[32*k +: 8];
        end
      end
    end
  end

  // Console FIFO: a full FIFO still accepts a push when the head pops the same cycle
  always_comb begin
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    pop      = con_rd & (count_q != '0);
    push_ok  = push & (~full | pop);
    ovf_d    = ovf_q | (push & full & ~pop);
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= ST_RUN;
      win_cnt_q  <= '0;
      seen_q     <= 1'b0;
      inst_cnt_q <= '0;
      hit_q      <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      seen_q     <= seen_d;
      inst_cnt_q <= inst_cnt_d;
      hit_q      <= hit_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: the pointers define what is live
  always_ff @(posedge clk) begin
    if (rst_b && push_ok) begin
      mem_q[wr_ptr_q] <= push_byte;
    end
  end

  always_comb begin
    con_vld        = (count_q != '0);
    con_byte       = con_vld ? mem_q[rd_ptr_q] : 8'h00;
    con_ovf        = ovf_q;
    status_pass    = (state_q == ST_PASS);
    status_fail    = (state_q == ST_FAIL);
    status_timeout = (state_q == ST_TIMEOUT);
    status_done    = (state_q != ST_RUN);
    inst_cnt       = inst_cnt_q;
  end

endmodule
